// File: rtl/mux_rr_4to1.sv
// Four-input round-robin merge of per-class word queues onto one registered stream.
// Define MUX_STRICT_PRIO_EN to replace round-robin with fixed priority (input 0 highest).
module mux_rr_4to1 #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  valid_0,
  input  logic                  valid_1,
  input  logic                  valid_2,
  input  logic                  valid_3,
  input  logic                  pause,
  output logic                  pop_0,
  output logic                  pop_1,
  output logic                  pop_2,
  output logic                  pop_3,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            class_out,
  output logic                  valid_out,
  output logic [15:0]           word_count
);

  logic [3:0]            valid_vec;
  logic [DATA_WIDTH-1:0] data_arr [4];
  logic [1:0]            grant_idx;
  logic                  any_grant;
  logic                  pop_any;
  logic [3:0]            pop_vec;

  assign valid_vec   = {valid_3, valid_2, valid_1, valid_0};
  assign data_arr[0] = data_in0;
  assign data_arr[1] = data_in1;
  assign data_arr[2] = data_in2;
  assign data_arr[3] = data_in3;

`ifdef MUX_STRICT_PRIO_EN
  // Scan from the lowest priority upward so the lowest valid index wins.
  always_comb begin
    grant_idx = 2'd0;
    any_grant = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (valid_vec[k]) begin
        grant_idx = 2'(k);
        any_grant = 1'b1;
      end
    end
  end
`else
  logic [1:0] ptr_reg;
  logic [1:0] cand;

  // Offsets scanned from ptr+3 down to ptr, so the offset nearest ptr wins.
  always_comb begin
    grant_idx = ptr_reg;
    any_grant = 1'b0;
    cand      = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_reg + 2'(k);
      if (valid_vec[cand]) begin
        grant_idx = cand;
        any_grant = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      ptr_reg <= 2'd0;
    end else if (pop_any) begin
      ptr_reg <= grant_idx + 2'd1;
    end
  end
`endif

  // Reset gates the pops directly so no queue head is consumed while in reset.
  assign pop_any = any_grant & ~pause & reset_L;
  assign pop_vec = pop_any ? (4'b0001 << grant_idx) : 4'b0000;
  assign pop_0   = pop_vec[0];
  assign pop_1   = pop_vec[1];
  assign pop_2   = pop_vec[2];
  assign pop_3   = pop_vec[3];

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      data_out   <= '0;
      class_out  <= 2'd0;
      valid_out  <= 1'b0;
      word_count <= 16'd0;
    end else if (pop_any) begin
      data_out   <= data_arr[grant_idx];
      class_out  <= grant_idx;
      valid_out  <= 1'b1;
      word_count <= word_count + 16'd1;
    end else begin
      valid_out  <= 1'b0;
    end
  end

endmodule
